// File: rtl/btb_update_arbiter_pkg.sv
// Shared types for execute -> BTB update traffic.
//   PC_WIDTH  : width of branch PC and resolved target
//   btb_upd_t : one resolved-branch update {pc, target}
//   occ_width : width of an occupancy count for a FIFO of a given depth
package btb_update_arbiter_pkg;

    localparam int unsigned PC_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
    } btb_upd_t;

    // Occupancy needs one bit beyond the pointer width to represent "full".
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Two-write / one-read update FIFO with ordered tail allocation and flush.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : drop same-cycle writes and empty the FIFO at the next edge
//   wr0, din0    : older write, lands at tail
//   wr1, din1    : younger write, lands at tail+wr0
//   rd           : pop head (caller guarantees count != 0)
//   dout         : head entry, straight from storage
//   count        : current occupancy
module btb_upd_fifo
    import btb_update_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr0,
    input  btb_upd_t                 din0,
    input  logic                     wr1,
    input  btb_upd_t                 din1,
    input  logic                     rd,
    output btb_upd_t                 dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = occ_width(DEPTH);

    btb_upd_t           mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   occ;
    logic               we0;
    logic               we1;
    logic               re;

    // Flush and reset both discard incoming writes and suppress the pop.
    assign we0 = wr0 & ~flush & ~reset;
    assign we1 = wr1 & ~flush & ~reset;
    assign re  = rd  & ~flush & ~reset;

    // Storage: younger write goes one slot past the older one when both land.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[tail] <= din0;
        end
        if (we1) begin
            mem[tail + PTR_W'(we0)] <= din1;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + PTR_W'(re);
            tail <= tail + PTR_W'(we0) + PTR_W'(we1);
            occ  <= occ + OCC_W'(we0) + OCC_W'(we1) - OCC_W'(re);
        end
    end

    assign dout  = mem[head];
    assign count = occ;

endmodule

// File: rtl/btb_update_arbiter.sv
// Arbitrates two execute-stage branch resolution sources onto the single BTB update port.
//   clk, reset                  : clock, synchronous active-high reset
//   s0_valid/ready/pc/target    : ALU0 update (older)
//   s1_valid/ready/pc/target    : ALU1 update (younger)
//   flush                       : discard all pending updates
//   hold                        : suppress draining this cycle
//   btb_req_valid/pc/target     : BTB update port (no backpressure)
//   pending                     : FIFO occupancy (EMPTY=0, ACTIVE, FULL=DEPTH)
//   issued_cnt                  : saturating count of delivered updates
module btb_update_arbiter
    import btb_update_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [PC_WIDTH-1:0]    s0_pc,
    input  logic [PC_WIDTH-1:0]    s0_target,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [PC_WIDTH-1:0]    s1_pc,
    input  logic [PC_WIDTH-1:0]    s1_target,
    input  logic                   flush,
    input  logic                   hold,
    output logic                   btb_req_valid,
    output logic [PC_WIDTH-1:0]    btb_req_pc,
    output logic [PC_WIDTH-1:0]    btb_req_target,
    output logic [$clog2(DEPTH):0] pending,
    output logic [CNT_WIDTH-1:0]   issued_cnt
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    btb_upd_t         din0;
    btb_upd_t         din1;
    btb_upd_t         head;
    logic [OCC_W-1:0] occ;
    logic             acc0;
    logic             acc1;
    logic             drain;

    // Readies look only at registered occupancy: s1 needs room behind a possible s0.
    assign s0_ready = (occ <= OCC_W'(DEPTH - 1));
    assign s1_ready = (occ <= OCC_W'(DEPTH - 2));

    assign acc0 = s0_valid & s0_ready;
    assign acc1 = s1_valid & s1_ready;

    assign din0 = '{pc: s0_pc, target: s0_target};
    assign din1 = '{pc: s1_pc, target: s1_target};

    // Drain one entry per cycle unless held, flushed or in reset.
    assign drain = (occ != '0) & ~hold & ~flush & ~reset;

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wr0   (acc0),
        .din0  (din0),
        .wr1   (acc1),
        .din1  (din1),
        .rd    (drain),
        .dout  (head),
        .count (occ)
    );

    // Delivered-update counter, saturating at all-ones; survives flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_cnt <= '0;
        end else if (drain && (issued_cnt != '1)) begin
            issued_cnt <= issued_cnt + CNT_WIDTH'(1);
        end
    end

    assign btb_req_valid  = drain;
    assign btb_req_pc     = head.pc;
    assign btb_req_target = head.target;
    assign pending        = occ;

endmodule

// File: tb/tb_btb_update_arbiter.sv
module tb_btb_update_arbiter;
    import btb_update_arbiter_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   s0_valid, s1_valid;
    logic                   s0_ready, s1_ready;
    logic [PC_WIDTH-1:0]    s0_pc, s0_target, s1_pc, s1_target;
    logic                   flush, hold;
    logic                   btb_req_valid;
    logic [PC_WIDTH-1:0]    btb_req_pc, btb_req_target;
    logic [$clog2(DEPTH):0] pending;
    logic [CNT_WIDTH-1:0]   issued_cnt;

    int checks = 0;
    int passes = 0;
    btb_upd_t exp_q[$];

    btb_update_arbiter #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .s0_valid       (s0_valid),
        .s0_ready       (s0_ready),
        .s0_pc          (s0_pc),
        .s0_target      (s0_target),
        .s1_valid       (s1_valid),
        .s1_ready       (s1_ready),
        .s1_pc          (s1_pc),
        .s1_target      (s1_target),
        .flush          (flush),
        .hold           (hold),
        .btb_req_valid  (btb_req_valid),
        .btb_req_pc     (btb_req_pc),
        .btb_req_target (btb_req_target),
        .pending        (pending),
        .issued_cnt     (issued_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; everything is sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_upd(input logic [PC_WIDTH-1:0] pc, input logic [PC_WIDTH-1:0] tgt);
        btb_upd_t e;
        e.pc = pc;
        e.target = tgt;
        exp_q.push_back(e);
    endtask

    // Monitor: every BTB request must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && btb_req_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL btb_req unexpected: pc=%0h tgt=%0h, expected no request (t=%0t)",
                         btb_req_pc, btb_req_target, $time);
            end else begin
                btb_upd_t e;
                e = exp_q.pop_front();
                if (btb_req_pc === e.pc && btb_req_target === e.target) passes++;
                else $display("FAIL btb_req data: pc=%0h tgt=%0h, expected pc=%0h tgt=%0h (t=%0t)",
                              btb_req_pc, btb_req_target, e.pc, e.target, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_pc = '0; s0_target = '0; s1_pc = '0; s1_target = '0;
        tick(); tick();
        reset = 1'b0;
        mid();
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset issued_cnt", 64'(issued_cnt), 64'd0);
        chk("reset btb_req_valid", 64'(btb_req_valid), 64'd0);
        chk("reset s0_ready", 64'(s0_ready), 64'd1);
        chk("reset s1_ready", 64'(s1_ready), 64'd1);

        // Single s0 push, one-cycle latency to the BTB.
        tick();
        s0_valid = 1'b1; s0_pc = 32'h100; s0_target = 32'h200;
        expect_upd(32'h100, 32'h200);
        tick();
        s0_valid = 1'b0;
        mid();
        chk("single pending", 64'(pending), 64'd1);
        chk("single valid", 64'(btb_req_valid), 64'd1);
        tick();
        mid();
        chk("single drained pending", 64'(pending), 64'd0);
        chk("single issued_cnt", 64'(issued_cnt), 64'd1);
        chk("single idle valid", 64'(btb_req_valid), 64'd0);

        // Dual push: s0 ahead of s1.
        tick();
        s0_valid = 1'b1; s0_pc = 32'h100; s0_target = 32'h200;
        s1_valid = 1'b1; s1_pc = 32'h300; s1_target = 32'h400;
        expect_upd(32'h100, 32'h200);
        expect_upd(32'h300, 32'h400);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        mid();
        chk("dual pending", 64'(pending), 64'd2);
        tick();
        mid();
        chk("dual pending after 1", 64'(pending), 64'd1);
        tick();
        mid();
        chk("dual drained", 64'(pending), 64'd0);
        chk("dual issued_cnt", 64'(issued_cnt), 64'd3);

        // Hold: fill to DEPTH, then drain in order.
        for (int i = 0; i < 4; i++) begin
            tick();
            hold = 1'b1;
            s0_valid = 1'b1; s0_pc = 32'h1000 + 32'(i); s0_target = 32'h2000 + 32'(i);
            expect_upd(32'h1000 + 32'(i), 32'h2000 + 32'(i));
            mid();
            chk("hold fill pending", 64'(pending), 64'(i));
            if (i == 3) begin
                chk("hold s1_ready at 3", 64'(s1_ready), 64'd0);
                chk("hold s0_ready at 3", 64'(s0_ready), 64'd1);
            end
        end
        tick();
        s0_valid = 1'b0;
        mid();
        chk("hold full pending", 64'(pending), 64'd4);
        chk("hold full s0_ready", 64'(s0_ready), 64'd0);
        chk("hold full s1_ready", 64'(s1_ready), 64'd0);
        chk("hold no drain", 64'(btb_req_valid), 64'd0);
        tick();
        mid();
        chk("hold persists", 64'(pending), 64'd4);
        tick();
        hold = 1'b0;
        for (int j = 0; j < 4; j++) begin
            mid();
            chk("release drain pending", 64'(pending), 64'(4 - j));
            chk("release drain valid", 64'(btb_req_valid), 64'd1);
            tick();
        end
        mid();
        chk("release drained", 64'(pending), 64'd0);
        chk("release issued_cnt", 64'(issued_cnt), 64'd7);

        // Flush with pending=3 and a same-cycle push; none of it may reach the BTB.
        for (int k = 0; k < 3; k++) begin
            tick();
            hold = 1'b1;
            s0_valid = 1'b1; s0_pc = 32'hF00 + 32'(k); s0_target = 32'hE00 + 32'(k);
            mid();
        end
        tick();
        hold = 1'b0; flush = 1'b1;
        s0_valid = 1'b1; s0_pc = 32'hDEAD; s0_target = 32'hBEEF;
        mid();
        chk("flush cycle pending", 64'(pending), 64'd3);
        chk("flush cycle valid", 64'(btb_req_valid), 64'd0);
        tick();
        flush = 1'b0; s0_valid = 1'b0;
        mid();
        chk("after flush pending", 64'(pending), 64'd0);
        chk("after flush valid", 64'(btb_req_valid), 64'd0);
        chk("after flush issued_cnt", 64'(issued_cnt), 64'd7);

        // Wrap-around: 10 back-to-back single pushes alternating sources.
        for (int i = 0; i < 10; i++) begin
            tick();
            s0_valid = (i % 2 == 0);
            s1_valid = (i % 2 == 1);
            s0_pc = 32'h5000 + 32'(i); s0_target = 32'h6000 + 32'(i);
            s1_pc = 32'h5000 + 32'(i); s1_target = 32'h6000 + 32'(i);
            expect_upd(32'h5000 + 32'(i), 32'h6000 + 32'(i));
            mid();
            chk("wrap pending", 64'(pending), (i == 0) ? 64'd0 : 64'd1);
        end
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        mid();
        chk("wrap tail pending", 64'(pending), 64'd1);
        tick();
        mid();
        chk("wrap drained", 64'(pending), 64'd0);
        chk("wrap issued_cnt", 64'(issued_cnt), 64'd17);

        // Reset mid-operation at pending=2.
        tick();
        hold = 1'b1;
        s0_valid = 1'b1; s0_pc = 32'h7000; s0_target = 32'h7100;
        s1_valid = 1'b1; s1_pc = 32'h7200; s1_target = 32'h7300;
        mid();
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        mid();
        chk("pre-reset pending", 64'(pending), 64'd2);
        tick();
        reset = 1'b1;
        mid();
        tick();
        reset = 1'b0; hold = 1'b0;
        mid();
        chk("mid reset pending", 64'(pending), 64'd0);
        chk("mid reset issued_cnt", 64'(issued_cnt), 64'd0);
        chk("mid reset valid", 64'(btb_req_valid), 64'd0);
        chk("mid reset s0_ready", 64'(s0_ready), 64'd1);
        chk("mid reset s1_ready", 64'(s1_ready), 64'd1);
        tick(); tick();
        mid();
        chk("no stray requests", 64'(btb_req_valid), 64'd0);
        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
